// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand forwarding select and load-use stall detection,
//               driven by an internal history of in-flight register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic                      issue_load,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [NUM_SRC-1:0]        src_use,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_regdata,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [NUM_SRC*DATA_W-1:0] operand,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    // History: entry k describes the instruction issued k cycles ago.
    logic [DEPTH:1]    r_valid;
    logic [DEPTH:1]    r_wr;
    logic [DEPTH:1]    r_load;
    logic [REG_AW-1:0] r_rd [1:DEPTH];
    logic [15:0]       r_stall_cnt;

    logic [NUM_SRC-1:0] w_load_hazard;
    logic               w_stall;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic [REG_AW-1:0] w_addr;
            logic [DEPTH:1]    w_match;
            logic [SEL_W-1:0]  w_sel;
            logic              w_hazard;
            logic [DATA_W-1:0] w_op;

            assign w_addr = src_addr[i*REG_AW +: REG_AW];

            always_comb begin
                w_match = '0;
                for (int k = 1; k <= DEPTH; k++) begin
                    w_match[k] = r_valid[k] & r_wr[k] & (r_rd[k] == w_addr)
                               & (w_addr != '0) & src_use[i];
                end
            end

            // Scan oldest to youngest so the youngest match is left standing.
            always_comb begin
                w_sel    = '0;
                w_hazard = 1'b0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (w_match[k]) begin
                        w_sel    = SEL_W'(k);
                        w_hazard = r_load[k] && (k < LOAD_LAT);
                    end
                end
            end

            always_comb begin
                w_op = src_regdata[i*DATA_W +: DATA_W];
                for (int k = 1; k <= DEPTH; k++) begin
                    if (w_sel == SEL_W'(k)) begin
                        w_op = stage_data[(k-1)*DATA_W +: DATA_W];
                    end
                end
            end

            assign w_load_hazard[i]              = w_hazard;
            assign fwd_sel[i*SEL_W +: SEL_W]     = w_sel;
            assign operand[i*DATA_W +: DATA_W]   = w_op;
        end
    endgenerate

    assign w_stall   = |w_load_hazard;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    // A stalled or flushed instruction still advances, but as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= '0;
            r_wr        <= '0;
            r_load      <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= '0;
            end
            r_stall_cnt <= '0;
        end else if (!hold) begin
            r_valid[1] <= issue_valid & ~w_stall & ~flush;
            r_wr[1]    <= issue_wr;
            r_load[1]  <= issue_load;
            r_rd[1]    <= issue_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed table-driven bench for fwd_hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = 2;

    localparam logic [31:0] c_rf0 = 32'h0000_1111;
    localparam logic [31:0] c_rf1 = 32'h0000_2222;
    localparam logic [31:0] c_s0  = 32'h0000_AAAA;
    localparam logic [31:0] c_s1  = 32'h0000_BBBB;
    localparam logic [31:0] c_s2  = 32'h0000_CCCC;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      hold, flush;
    logic                      issue_valid, issue_wr, issue_load;
    logic [REG_AW-1:0]         issue_rd;
    logic [NUM_SRC-1:0]        src_use;
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0] src_regdata;
    logic [DEPTH*DATA_W-1:0]   stage_data;
    logic [NUM_SRC*DATA_W-1:0] operand;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic [15:0]               stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
        .DEPTH(DEPTH), .LOAD_LAT(2), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_load(issue_load),
        .issue_rd(issue_rd), .src_use(src_use), .src_addr(src_addr),
        .src_regdata(src_regdata), .stage_data(stage_data),
        .operand(operand), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hold, flush, iv, wr, ld;
        logic [4:0] rd;
        logic [1:0] su;
        logic [4:0] a0, a1;
        logic [1:0] s0, s1;
        logic       st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic h, logic f, logic iv, logic wr, logic ld,
                                logic [4:0] rd, logic [1:0] su, logic [4:0] a0,
                                logic [4:0] a1, logic [1:0] s0, logic [1:0] s1,
                                logic st, logic [15:0] cnt);
        vec_t v;
        v.hold = h; v.flush = f; v.iv = iv; v.wr = wr; v.ld = ld; v.rd = rd;
        v.su = su; v.a0 = a0; v.a1 = a1; v.s0 = s0; v.s1 = s1; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    // Fixed stage results: entry 1/2/3 carry AAAA/BBBB/CCCC.
    function automatic logic [31:0] exp_op(logic [1:0] sel, logic [31:0] rf);
        case (sel)
            2'd1:    return c_s0;
            2'd2:    return c_s1;
            2'd3:    return c_s2;
            default: return rf;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic f, input logic iv, input logic wr,
                         input logic ld, input logic [4:0] rd, input logic [1:0] su,
                         input logic [4:0] a0, input logic [4:0] a1);
        hold = h; flush = f; issue_valid = iv; issue_wr = wr; issue_load = ld;
        issue_rd = rd; src_use = su; src_addr = {a1, a0};
    endtask

    initial begin
        // Rows: hold flush iv wr ld rd | use a0 a1 | sel0 sel1 stall cnt
        vecs.push_back(mk(0,0,1,1,0, 3, 2'b00, 0, 0, 0,0,0,0)); // write r3
        vecs.push_back(mk(0,0,1,1,0, 3, 2'b01, 3, 0, 1,0,0,0)); // write r3 again
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 3, 0, 1,0,0,0)); // youngest r3 wins
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 3, 0, 2,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 3, 0, 3,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 3, 0, 0,0,0,0)); // fell off
        vecs.push_back(mk(0,0,1,1,1, 4, 2'b00, 0, 0, 0,0,0,0)); // load r4
        vecs.push_back(mk(0,0,1,1,0,10, 2'b10, 0, 4, 0,1,1,0)); // load-use stall
        vecs.push_back(mk(0,0,1,1,0,10, 2'b10, 0, 4, 0,2,0,1)); // bubble aged load
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b11,10, 4, 1,3,0,1));
        vecs.push_back(mk(0,0,1,1,0, 0, 2'b01,10, 0, 2,0,0,1)); // write r0
        vecs.push_back(mk(0,0,1,0,0, 7, 2'b11, 0,10, 0,3,0,1)); // r0 never matches
        vecs.push_back(mk(0,0,1,1,0,12, 2'b11, 7, 0, 0,0,0,1)); // non-write r7
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b10,12,12, 0,1,0,1)); // src_use masks
        vecs.push_back(mk(0,0,1,1,0, 9, 2'b00, 0, 0, 0,0,0,1)); // write r9
        vecs.push_back(mk(1,0,0,0,0, 0, 2'b01, 9, 0, 1,0,0,1)); // hold x3
        vecs.push_back(mk(1,0,1,1,1, 9, 2'b01, 9, 0, 1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0, 0, 2'b01, 9, 0, 1,0,0,1));
        vecs.push_back(mk(0,1,1,1,0, 6, 2'b01, 9, 0, 1,0,0,1)); // flushed r6
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b11, 6, 9, 0,2,0,1));
        vecs.push_back(mk(1,1,1,1,0, 5, 2'b01, 9, 0, 3,0,0,1)); // hold beats flush
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b11, 9, 5, 3,0,0,1));
        vecs.push_back(mk(0,0,1,1,1, 8, 2'b00, 0, 0, 0,0,0,1)); // load r8
        vecs.push_back(mk(1,0,0,0,0, 0, 2'b01, 8, 0, 1,0,1,1)); // stall under hold: no count
        vecs.push_back(mk(0,0,1,1,0,13, 2'b01, 8, 0, 1,0,1,1));
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 8, 0, 2,0,0,2));
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01, 8, 0, 3,0,0,2));
        vecs.push_back(mk(0,0,1,1,1,11, 2'b00, 0, 0, 0,0,0,2)); // load r11
        vecs.push_back(mk(0,0,1,1,0,11, 2'b00, 0, 0, 0,0,0,2)); // alu r11 younger
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b01,11, 0, 1,0,0,2)); // no stall
        vecs.push_back(mk(0,0,0,0,0, 0, 2'b11,11,11, 2,2,0,2));

        src_regdata = {c_rf1, c_rf0};
        stage_data  = {c_s2, c_s1, c_s0};
        drive(0,0,0,0,0,0,2'b00,0,0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].hold, vecs[n].flush, vecs[n].iv, vecs[n].wr, vecs[n].ld,
                  vecs[n].rd, vecs[n].su, vecs[n].a0, vecs[n].a1);
            #1;
            check($sformatf("row%0d sel0", n), 32'(fwd_sel[1:0]), 32'(vecs[n].s0));
            check($sformatf("row%0d sel1", n), 32'(fwd_sel[3:2]), 32'(vecs[n].s1));
            check($sformatf("row%0d stall", n), 32'(stall), 32'(vecs[n].st));
            check($sformatf("row%0d op0", n), operand[31:0], exp_op(vecs[n].s0, c_rf0));
            check($sformatf("row%0d op1", n), operand[63:32], exp_op(vecs[n].s1, c_rf1));
            check($sformatf("row%0d cnt", n), 32'(stall_cnt), 32'(vecs[n].cnt));
        end

        // Asynchronous reset with a live history entry for r5.
        @(negedge clk);
        drive(0,0,1,1,0,5,2'b01,5,0);
        @(negedge clk);
        drive(0,0,0,0,0,0,2'b01,5,0);
        #1;
        check("pre_reset sel0", 32'(fwd_sel[1:0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("in_reset sel0", 32'(fwd_sel[1:0]), 32'd0);
        check("in_reset op0", operand[31:0], c_rf0);
        check("in_reset stall", 32'(stall), 32'd0);
        check("in_reset cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset sel0", 32'(fwd_sel[1:0]), 32'd0);
        check("post_reset op0", operand[31:0], c_rf0);
        check("post_reset stall", 32'(stall), 32'd0);
        check("post_reset cnt", 32'(stall_cnt), 32'd0);

        // Saturation: preload the counter, then three stalled cycles.
        drive(0,0,1,1,1,8,2'b00,0,0);
        @(negedge clk);
        force dut.r_stall_cnt = 16'hFFFE;
        release dut.r_stall_cnt;
        drive(0,0,1,1,1,8,2'b01,8,0);
        #1;
        check("sat_preload cnt", 32'(stall_cnt), 32'h0000_FFFE);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("sat%0d stall_on", s), 32'(stall), 32'd1);
            @(negedge clk);
            #1;
            check($sformatf("sat%0d stall_off", s), 32'(stall), 32'd0);
            check($sformatf("sat%0d cnt", s), 32'(stall_cnt), 32'h0000_FFFF);
            @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's operand-forwarding select.
- Keeps its own history of in-flight register writes, one entry per downstream stage. Compares each ID-stage source against that history. Produces the forwarded operand, its select code and a load-use stall.
- Sits between ID and EX. The datapath supplies stage results; the block decides forwarding and stalls internally.

Parameters:
- DATA_W, 32, operand and result width.
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked per instruction.
- DEPTH, 3, number of tracked downstream stages (entry k = instruction issued k cycles ago); must be >= 1.
- LOAD_LAT, 2, first entry index at which load data is available; 1 <= LOAD_LAT <= DEPTH.
- SEL_W, $clog2(DEPTH+1), derived: select code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze.
- flush  in  1  kill the ID instruction; a bubble enters entry 1.
- issue_valid  in  1  ID holds a valid instruction.
- issue_wr  in  1  ID instruction writes a register.
- issue_load  in  1  ID instruction is a load.
- issue_rd  in  REG_AW  ID destination register.
- src_use  in  NUM_SRC  bit i: source i is read.
- src_addr  in  NUM_SRC*REG_AW  source register addresses; slot i at [i*REG_AW +: REG_AW].
- src_regdata  in  NUM_SRC*DATA_W  register-file read data per source.
- stage_data  in  DEPTH*DATA_W  result of entry k on slot k-1.
- operand  out  NUM_SRC*DATA_W  forwarded operand per source.
- fwd_sel  out  NUM_SRC*SEL_W  0 = register file; k = entry k.
- stall  out  1  load-use stall request.
- stall_cnt  out  16  saturating count of stalled cycles.

Behaviour:
- State per entry k (1..DEPTH): valid, wr, load, rd. History plus stall_cnt are the only registers.
- Reset (asynchronous, reset=0): all entries invalid; stall_cnt=0.
  - Consequently stall=0, fwd_sel=0 and operand=src_regdata while in reset.
- Match rule for source i against entry k: valid & wr & rd==src_addr[i] & src_addr[i]!=0 & src_use[i].
  - Register 0 never matches.
- fwd_sel[i]: smallest matching k (youngest wins), else 0.
- operand[i]: stage_data slot k-1 if fwd_sel[i]=k, else src_regdata[i]. Purely combinational, same cycle.
- stall: 1 if, for any source, the youngest match has load=1 and k < LOAD_LAT. Combinational.
  - While stall=1, fwd_sel and operand still reflect the match; the consumer ignores them.
- Advance on each clock edge with hold=0:
  - Entries k>=2 take entry k-1.
  - Entry 1 takes {issue_valid & ~stall & ~flush, issue_wr, issue_load, issue_rd}.
  - The entry leaving DEPTH is discarded.
- hold=1: history and stall_cnt are unchanged; outputs are still evaluated.
  - hold has priority over flush. A flush asserted during hold is lost, and the controller re-asserts it.
- stall_cnt increments on edges with stall=1 & hold=0, and saturates at 16'hFFFF.
- A stalled instruction re-checks every cycle. The bubble ages the load to k=LOAD_LAT, stall drops, and the value forwards from that entry.
- No latency other than the history: forwarding decisions take effect in the same cycle as the inputs.

Test Plan:
- Reset: hold reset=0 mid-stream with valid entries. Release; set src_addr0=5, src_regdata0=0x1111, src_use=2'b01 -> operand0=0x1111, fwd_sel0=0, stall=0, stall_cnt=0.
- ALU chain: issue wr rd=3 (cycle0), issue wr rd=3 (cycle1). In cycle2 set src_addr0=3, stage_data slot0=0xAAAA, slot1=0xBBBB -> fwd_sel0=1, operand0=0xAAAA. Age two more cycles with no new rd=3 writes -> fwd_sel0=3.
- Load-use: issue load rd=4. Next cycle src_addr1=4, src_use[1]=1 -> stall=1. Following cycle (bubble in entry1) -> stall=0, fwd_sel1=2, operand1=stage_data slot1. stall_cnt=1.
- Register zero and non-writes: issue wr rd=0, then src_addr0=0 -> fwd_sel0=0. Issue wr=0 rd=7, then src_addr0=7 -> fwd_sel0=0.
- Hold/flush:
  - Issue wr rd=9, then hold=1 for 3 cycles with src_addr0=9 -> fwd_sel0 stays 1 and stall_cnt is unchanged.
  - flush=1 with issue wr rd=6, then src_addr0=6 -> fwd_sel0=0.
  - hold=1 and flush=1 together -> history unchanged.
- Aging and saturation:
  - After DEPTH+1 cycles with no new writes, an entry falls off -> fwd_sel=0.
  - Force stall_cnt to 0xFFFE and run 3 stalled cycles -> stall_cnt holds 0xFFFF.
